// File: rtl/mxv_pkg.sv
// Shared types and helpers for the MxV serial element link (send and receive sides).
//   rx_state_t : receive-side FSM state encoding
//   cnt_w(n)   : width of a counter that must hold the values 0..n
package mxv_pkg;

   typedef enum logic [1:0] {
      RX_IDLE = 2'd0,
      RX_RECV = 2'd1,
      RX_HOLD = 2'd2
   } rx_state_t;

   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/rx_idle_timer.sv
// Idle watchdog for a partially received frame. Down-counter reloaded with
// TIMEOUT_CYCLES on restart; decrements on each cycle where count is high.
// expire is high in the cycle that consumes the last remaining idle cycle.
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous, active-low
//   restart  in   reload the counter (elapsed idle time back to zero)
//   count    in   this cycle is an idle cycle
//   expire   out  terminal count reached this cycle
module rx_idle_timer #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   input  logic count,
   output logic expire
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] RELOAD = TW'(TIMEOUT_CYCLES);

   logic [TW-1:0] remain;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         remain <= RELOAD;
      end else if (restart) begin
         remain <= RELOAD;
      end else if (count && remain != '0) begin
         remain <= remain - 1'b1;
      end
   end

   assign expire = count & ~restart & (remain == TW'(1));

endmodule

// File: rtl/vector_receive.sv
// Receive end of the MxV serial element link. Packs N_ELEMS elements, one per
// in_valid & in_ready beat, into a parallel vector and holds it for the MAC
// array until vec_ack.
// Optional feature: define RX_TIMEOUT_EN to abort a partial frame after
// TIMEOUT_CYCLES idle cycles in RECV (reported by a one-cycle timeout_err).
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous, active-low
//   clear        in   synchronous flush, active-high (highest priority)
//   in_valid     in   element present on in_data
//   in_data      in   element payload
//   in_ready     out  receiver can accept an element this cycle
//   vec_data     out  assembled vector, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   vec_valid    out  vec_data complete and stable
//   vec_ack      in   consumer has taken vec_data (only honoured in HOLD)
//   elem_count   out  elements captured in the current frame
//   timeout_err  out  one-cycle pulse when a partial frame is aborted
//
// state   | meaning
// RX_IDLE | no frame in progress, next beat is element 0
// RX_RECV | frame partially received, waiting for further elements
// RX_HOLD | vector complete, vec_valid high until vec_ack
module vector_receive
   import mxv_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int N_ELEMS        = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          clear,
   input  logic                          in_valid,
   input  logic [DATA_WIDTH-1:0]         in_data,
   output logic                          in_ready,
   output logic [N_ELEMS*DATA_WIDTH-1:0] vec_data,
   output logic                          vec_valid,
   input  logic                          vec_ack,
   output logic [cnt_w(N_ELEMS)-1:0]     elem_count,
   output logic                          timeout_err
);

   localparam int CW = cnt_w(N_ELEMS);
   localparam logic [CW-1:0] LAST_IDX = CW'(N_ELEMS - 1);
   localparam logic [CW-1:0] FULL     = CW'(N_ELEMS);

   rx_state_t state;
   logic      beat;
   logic      expire;

   assign in_ready = (state != RX_HOLD);
   assign beat     = in_valid & in_ready;

`ifdef RX_TIMEOUT_EN
   logic timer_restart;
   logic timer_count;

   // Elapsed idle time restarts on every beat and whenever we are outside RECV.
   assign timer_restart = clear | beat | (state != RX_RECV);
   assign timer_count   = (state == RX_RECV) & ~in_valid;

   rx_idle_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_idle_timer (
      .clk     (clk),
      .reset   (reset),
      .restart (timer_restart),
      .count   (timer_count),
      .expire  (expire)
   );

   // expire is already masked by clear through timer_restart.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= expire;
      end
   end
`else
   // TIMEOUT_CYCLES only matters when the watchdog is built in.
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = |TIMEOUT_CYCLES;
   assign expire      = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= RX_IDLE;
         vec_data   <= '0;
         vec_valid  <= 1'b0;
         elem_count <= '0;
      end else if (clear) begin
         // vec_data deliberately kept: the consumer may still be reading it.
         state      <= RX_IDLE;
         vec_valid  <= 1'b0;
         elem_count <= '0;
      end else begin
         case (state)
            RX_IDLE, RX_RECV: begin
               if (beat) begin
                  // Indexed write keeps earlier elements in place.
                  for (int i = 0; i < N_ELEMS; i++) begin
                     if (elem_count == CW'(i)) begin
                        vec_data[i*DATA_WIDTH +: DATA_WIDTH] <= in_data;
                     end
                  end
                  if (elem_count == LAST_IDX) begin
                     state      <= RX_HOLD;
                     vec_valid  <= 1'b1;
                     elem_count <= FULL;
                  end else begin
                     state      <= RX_RECV;
                     elem_count <= elem_count + 1'b1;
                  end
               end else if (expire) begin
                  state      <= RX_IDLE;
                  elem_count <= '0;
               end
            end
            RX_HOLD: begin
               if (vec_ack) begin
                  state      <= RX_IDLE;
                  vec_valid  <= 1'b0;
                  elem_count <= '0;
               end
            end
            default: begin
               state      <= RX_IDLE;
               vec_valid  <= 1'b0;
               elem_count <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vector_receive.sv
// Self-checking bench for vector_receive (DATA_WIDTH=8, N_ELEMS=4, TIMEOUT_CYCLES=16).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_vector_receive;

   logic        clk = 1'b0;
   logic        reset;
   logic        clear;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic [31:0] vec_data;
   logic        vec_valid;
   logic        vec_ack;
   logic [2:0]  elem_count;
   logic        timeout_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   vector_receive #(
      .DATA_WIDTH     (8),
      .N_ELEMS        (4),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .clear       (clear),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .vec_data    (vec_data),
      .vec_valid   (vec_valid),
      .vec_ack     (vec_ack),
      .elem_count  (elem_count),
      .timeout_err (timeout_err)
   );

   typedef struct {
      logic        clr;
      logic        v;
      logic [7:0]  d;
      logic        ack;
      logic        rdy;
      logic        vv;
      logic [31:0] data;
      logic [2:0]  cnt;
   } row_t;

   row_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic c, input logic v, input logic [7:0] d, input logic a);
      clear    = c;
      in_valid = v;
      in_data  = d;
      vec_ack  = a;
   endtask

   task automatic next_cycle();
      @(negedge clk);
   endtask

   logic [31:0] exp_vec;
   logic [7:0]  elem [4];
   int          frames_ok;
   int          waited;
   logic        got;

   initial begin
      reset = 1'b0;
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      next_cycle();
      next_cycle();
      #1;
      chk("reset_vec_data", vec_data, 32'h0);
      chk("reset_vec_valid", {31'b0, vec_valid}, 32'h0);
      chk("reset_elem_count", {29'b0, elem_count}, 32'h0);
      chk("reset_timeout_err", {31'b0, timeout_err}, 32'h0);
      chk("reset_in_ready", {31'b0, in_ready}, 32'h1);
      next_cycle();
      reset = 1'b1;

      //                 clr   v     d      ack   rdy   vv    data          cnt
      tbl.push_back('{1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 32'h00000000, 3'd0});
      tbl.push_back('{1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 32'h00000011, 3'd1});
      tbl.push_back('{1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 32'h00002211, 3'd2});
      tbl.push_back('{1'b0, 1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 32'h00332211, 3'd3});
      tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'h44332211, 3'd4});
      tbl.push_back('{1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 32'h44332211, 3'd4});
      tbl.push_back('{1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 32'h44332211, 3'd4});
      tbl.push_back('{1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 32'h44332211, 3'd0});
      tbl.push_back('{1'b0, 1'b1, 8'h66, 1'b0, 1'b1, 1'b0, 32'h44332255, 3'd1});
      tbl.push_back('{1'b0, 1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 32'h44336655, 3'd2});
      tbl.push_back('{1'b1, 1'b1, 8'h88, 1'b0, 1'b1, 1'b0, 32'h44776655, 3'd3});
      tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h44776655, 3'd0});
      tbl.push_back('{1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 32'h44776655, 3'd0});
      tbl.push_back('{1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 32'h447766A1, 3'd1});
      tbl.push_back('{1'b0, 1'b1, 8'hA2, 1'b1, 1'b1, 1'b0, 32'h447766A1, 3'd1});
      tbl.push_back('{1'b0, 1'b1, 8'hA3, 1'b0, 1'b1, 1'b0, 32'h4477A2A1, 3'd2});
      tbl.push_back('{1'b0, 1'b1, 8'hA4, 1'b0, 1'b1, 1'b0, 32'h44A3A2A1, 3'd3});
      tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'hA4A3A2A1, 3'd4});
      tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'hA4A3A2A1, 3'd4});
      tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'hA4A3A2A1, 3'd0});

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].clr, tbl[i].v, tbl[i].d, tbl[i].ack);
         #1;
         chk($sformatf("row%0d_in_ready", i), {31'b0, in_ready}, {31'b0, tbl[i].rdy});
         chk($sformatf("row%0d_vec_valid", i), {31'b0, vec_valid}, {31'b0, tbl[i].vv});
         chk($sformatf("row%0d_vec_data", i), vec_data, tbl[i].data);
         chk($sformatf("row%0d_elem_count", i), {29'b0, elem_count}, {29'b0, tbl[i].cnt});
         chk($sformatf("row%0d_timeout_err", i), {31'b0, timeout_err}, 32'h0);
         next_cycle();
      end

      // Asynchronous reset in the middle of a frame.
      drive(1'b0, 1'b1, 8'hB1, 1'b0);
      next_cycle();
      drive(1'b0, 1'b1, 8'hB2, 1'b0);
      next_cycle();
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      chk("midreset_vec_data", vec_data, 32'h0);
      chk("midreset_vec_valid", {31'b0, vec_valid}, 32'h0);
      chk("midreset_elem_count", {29'b0, elem_count}, 32'h0);
      chk("midreset_timeout_err", {31'b0, timeout_err}, 32'h0);
      next_cycle();
      reset = 1'b1;
      drive(1'b0, 1'b1, 8'hC1, 1'b0);
      next_cycle();
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      #1;
      chk("postreset_vec_data", vec_data, 32'h000000C1);
      chk("postreset_elem_count", {29'b0, elem_count}, 32'h1);
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      next_cycle();
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      #1;
      chk("clear_elem_count", {29'b0, elem_count}, 32'h0);

`ifdef RX_TIMEOUT_EN
      // Two beats then 16 idle cycles: single abort pulse.
      drive(1'b0, 1'b1, 8'hD1, 1'b0);
      next_cycle();
      drive(1'b0, 1'b1, 8'hD2, 1'b0);
      next_cycle();
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      got = 1'b0;
      for (int i = 0; i < 15; i++) begin
         next_cycle();
         #1;
         if (timeout_err !== 1'b0 || elem_count !== 3'd2) got = 1'b1;
      end
      chk("tmo_early_error", {31'b0, got}, 32'h0);
      next_cycle();
      #1;
      chk("tmo_pulse", {31'b0, timeout_err}, 32'h1);
      chk("tmo_elem_count", {29'b0, elem_count}, 32'h0);
      next_cycle();
      #1;
      chk("tmo_pulse_end", {31'b0, timeout_err}, 32'h0);
      // 15 idle cycles then a beat: no abort.
      drive(1'b0, 1'b1, 8'hE1, 1'b0);
      next_cycle();
      drive(1'b0, 1'b1, 8'hE2, 1'b0);
      next_cycle();
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 15; i++) next_cycle();
      drive(1'b0, 1'b1, 8'hE3, 1'b0);
      got = 1'b0;
      for (int i = 0; i < 8; i++) begin
         next_cycle();
         drive(1'b0, 1'b0, 8'h00, 1'b0);
         #1;
         if (timeout_err !== 1'b0) got = 1'b1;
      end
      chk("tmo15_no_error", {31'b0, got}, 32'h0);
      chk("tmo15_elem_count", {29'b0, elem_count}, 32'h3);
      chk("tmo15_vec_data", vec_data & 32'h00FFFFFF, 32'h00E3E2E1);
`else
      // Without the watchdog a partial frame waits indefinitely.
      drive(1'b0, 1'b1, 8'hD1, 1'b0);
      next_cycle();
      drive(1'b0, 1'b1, 8'hD2, 1'b0);
      next_cycle();
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         next_cycle();
         #1;
         if (timeout_err !== 1'b0) got = 1'b1;
      end
      chk("notmo_no_error", {31'b0, got}, 32'h0);
      chk("notmo_elem_count", {29'b0, elem_count}, 32'h2);
      chk("notmo_in_ready", {31'b0, in_ready}, 32'h1);
`endif
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      next_cycle();
      drive(1'b0, 1'b0, 8'h00, 1'b0);

      // Gapped traffic with random acknowledge delay, scoreboarded per frame.
      frames_ok = 0;
      for (int f = 0; f < 200; f++) begin
         for (int e = 0; e < 4; e++) elem[e] = 8'($urandom);
         exp_vec = {elem[3], elem[2], elem[1], elem[0]};
         for (int e = 0; e < 4; e++) begin
            drive(1'b0, 1'b0, 8'($urandom), 1'b0);
            for (int g = $urandom_range(0, 2); g > 0; g--) next_cycle();
            drive(1'b0, 1'b1, elem[e], 1'b0);
            #1;
            waited = 0;
            while (in_ready !== 1'b1 && waited < 10) begin
               next_cycle();
               #1;
               waited++;
            end
            if (waited >= 10) chk($sformatf("f%0d_ready_timeout", f), {31'b0, in_ready}, 32'h1);
            next_cycle();
         end
         drive(1'b0, 1'b0, 8'h00, 1'b0);
         #1;
         waited = 0;
         while (vec_valid !== 1'b1 && waited < 5) begin
            next_cycle();
            #1;
            waited++;
         end
         chk($sformatf("f%0d_latency", f), waited, 0);
         chk($sformatf("f%0d_vec_data", f), vec_data, exp_vec);
         chk($sformatf("f%0d_elem_count", f), {29'b0, elem_count}, 32'h4);
         for (int d = $urandom_range(0, 5); d > 0; d--) next_cycle();
         #1;
         chk($sformatf("f%0d_held", f), {vec_data[30:0], vec_valid}, {exp_vec[30:0], 1'b1});
         drive(1'b0, 1'b0, 8'h00, 1'b1);
         next_cycle();
         drive(1'b0, 1'b0, 8'h00, 1'b0);
         #1;
         chk($sformatf("f%0d_ack_drop", f), {30'b0, vec_valid, in_ready}, 32'h1);
         if (vec_data === exp_vec && vec_valid === 1'b0) frames_ok++;
      end
      chk("frames_received", frames_ok, 200);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
